// File: rtl/mem_stage.sv
// LC-3b memory-access stage: performs loads/stores (incl. indirect) over a
// single-port mem_resp handshake, stalls upstream while an access is
// outstanding, and registers writeback values for the writeback stage.
module mem_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [2:0]       mem_op_in,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] sdata_in,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [2:0]       dr_in,
    input  logic             ld_regfile_in,
    output logic             stall_out,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_byte_enable,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    output logic [2:0]       wb_dr,
    output logic             wb_ld_regfile
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC1 = 2'd1;
    localparam logic [1:0] ACC2 = 2'd2;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LDW  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_STW  = 3'd3;
    localparam logic [2:0] OP_STB  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_STI  = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    logic [2:0]       dr_q, dr_d;
    logic             ld_q, ld_d;

    logic             mem_read_d, mem_write_d;
    logic [1:0]       be_d;
    logic [WIDTH-1:0] maddr_d, wdata_d;
    logic             wb_valid_d, wb_ld_d;
    logic [WIDTH-1:0] wb_data_d;
    logic [2:0]       wb_dr_d;

    logic             stall_c;
    logic             final_resp;
    logic             in_is_mem, in_is_byte, in_is_store;
    logic             q_is_load, q_is_indirect;
    logic [7:0]       rbyte;

    // Decode of the incoming and the latched operation
    always_comb begin
        in_is_mem     = (mem_op_in != OP_NONE) && (mem_op_in != OP_RSV);
        in_is_byte    = (mem_op_in == OP_LDB) || (mem_op_in == OP_STB);
        in_is_store   = (mem_op_in == OP_STW) || (mem_op_in == OP_STB);
        q_is_load     = (op_q == OP_LDW) || (op_q == OP_LDB) || (op_q == OP_LDI);
        q_is_indirect = (op_q == OP_LDI) || (op_q == OP_STI);
        rbyte         = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    end

    // Next-state, memory request and writeback computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        dr_d        = dr_q;
        ld_d        = ld_q;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        be_d        = mem_byte_enable;
        maddr_d     = mem_address;
        wdata_d     = mem_wdata;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data;
        wb_dr_d     = wb_dr;
        wb_ld_d     = wb_ld_regfile;
        stall_c     = 1'b0;
        final_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in && in_is_mem) begin
                    state_d     = ACC1;
                    stall_c     = 1'b1;
                    op_d        = mem_op_in;
                    addr_d      = addr_in;
                    sdata_d     = sdata_in;
                    dr_d        = dr_in;
                    ld_d        = ld_regfile_in;
                    mem_read_d  = !in_is_store;
                    mem_write_d = in_is_store;
                    if (in_is_byte) begin
                        maddr_d = addr_in;
                        be_d    = addr_in[0] ? 2'b10 : 2'b01;
                    end else begin
                        maddr_d = {addr_in[WIDTH-1:1], 1'b0};
                        be_d    = 2'b11;
                    end
                    wdata_d = (mem_op_in == OP_STB) ? WIDTH'({sdata_in[7:0], sdata_in[7:0]})
                                                    : sdata_in;
                end else if (valid_in && (mem_op_in == OP_NONE)) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_in;
                    wb_dr_d    = dr_in;
                    wb_ld_d    = ld_regfile_in;
                end
            end
            ACC1: begin
                if (mem_resp) begin
                    if (q_is_indirect) begin
                        state_d     = ACC2;
                        stall_c     = 1'b1;
                        maddr_d     = {mem_rdata[WIDTH-1:1], 1'b0};
                        be_d        = 2'b11;
                        mem_read_d  = (op_q == OP_LDI);
                        mem_write_d = (op_q == OP_STI);
                        wdata_d     = sdata_q;
                    end else begin
                        final_resp = 1'b1;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            ACC2: begin
                if (mem_resp) begin
                    final_resp = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (final_resp) begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            be_d        = 2'b00;
            wb_valid_d  = 1'b1;
            if (q_is_load) begin
                wb_data_d = (op_q == OP_LDB) ? {{(WIDTH-8){rbyte[7]}}, rbyte} : mem_rdata;
                wb_dr_d   = dr_q;
                wb_ld_d   = ld_q;
            end else begin
                wb_ld_d   = 1'b0;
            end
        end
    end

    assign stall_out = stall_c;

    // State, latched instruction, memory request and writeback registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            op_q            <= OP_NONE;
            addr_q          <= '0;
            sdata_q         <= '0;
            dr_q            <= '0;
            ld_q            <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 2'b00;
            mem_address     <= '0;
            mem_wdata       <= '0;
            wb_valid        <= 1'b0;
            wb_data         <= '0;
            wb_dr           <= '0;
            wb_ld_regfile   <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            addr_q          <= addr_d;
            sdata_q         <= sdata_d;
            dr_q            <= dr_d;
            ld_q            <= ld_d;
            mem_read        <= mem_read_d;
            mem_write       <= mem_write_d;
            mem_byte_enable <= be_d;
            mem_address     <= maddr_d;
            mem_wdata       <= wdata_d;
            wb_valid        <= wb_valid_d;
            wb_data         <= wb_data_d;
            wb_dr           <= wb_dr_d;
            wb_ld_regfile   <= wb_ld_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against a word-addressed memory model and a
// writeback model built from the stage's architectural rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [2:0]  mem_op_in;
    logic [15:0] addr_in, sdata_in, alu_in;
    logic [2:0]  dr_in;
    logic        ld_regfile_in;
    logic        stall_out;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_dr;
    logic        wb_ld_regfile;

    mem_stage #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_op_in(mem_op_in),
        .addr_in(addr_in), .sdata_in(sdata_in), .alu_in(alu_in), .dr_in(dr_in),
        .ld_regfile_in(ld_regfile_in), .stall_out(stall_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_dr(wb_dr), .wb_ld_regfile(wb_ld_regfile)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int write_cycles = 0;

    logic [15:0] mem_model [int];
    logic [15:0] exp_data;
    logic [2:0]  exp_dr;
    logic        exp_ld;

    function automatic logic [15:0] mread(input logic [15:0] a);
        int k;
        k = int'(a >> 1);
        if (!mem_model.exists(k)) mem_model[k] = 16'($urandom);
        return mem_model[k];
    endfunction

    function automatic void mwrite(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] w;
        w = mread(a);
        if (be[0]) w[7:0]  = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        mem_model[int'(a >> 1)] = w;
    endfunction

    // Non-memory op; called just after a negedge, returns at the retire negedge
    task automatic run_none(input logic [15:0] alu, input logic [2:0] dr, input logic ld);
        valid_in = 1'b1; mem_op_in = 3'd0; alu_in = alu; dr_in = dr; ld_regfile_in = ld;
        addr_in = 16'($urandom); sdata_in = 16'($urandom);
        #1;
        checks++;
        if (stall_out !== 1'b0) $display("FAIL none_stall: got %b want 0", stall_out);
        if (stall_out !== 1'b0) errors++;
        @(negedge clk);
        valid_in = 1'b0;
        exp_data = alu; exp_dr = dr; exp_ld = ld;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_dr !== exp_dr ||
            wb_ld_regfile !== exp_ld || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL none_wb: got v=%b d=%h dr=%0d ld=%b rd=%b wr=%b want v=1 d=%h dr=%0d ld=%b rd=0 wr=0",
                     wb_valid, wb_data, wb_dr, wb_ld_regfile, mem_read, mem_write, exp_data, exp_dr, exp_ld);
        end
    endtask

    // Memory op with memory latencies l1/l2 (cycles of request before mem_resp)
    task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] sdata,
                          input logic [2:0] dr, input logic ld, input int l1, input int l2);
        logic ind, is_load, is_byte, rd_req, wr_req, exp_stall;
        logic [15:0] req_addr, exp_wd, rd, ptr;
        logic [1:0]  be;
        int lat;
        ind     = (op == 3'd5) || (op == 3'd6);
        is_load = (op == 3'd1) || (op == 3'd2) || (op == 3'd5);
        is_byte = (op == 3'd2) || (op == 3'd4);
        rd = '0; ptr = '0;
        valid_in = 1'b1; mem_op_in = op; addr_in = addr; sdata_in = sdata;
        dr_in = dr; ld_regfile_in = ld; alu_in = 16'($urandom);
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL accept_stall op=%0d: got %b want 1", op, stall_out);
        end
        for (int acc = 0; acc < (ind ? 2 : 1); acc++) begin
            if (acc == 0) begin
                req_addr = is_byte ? addr : (addr & 16'hFFFE);
                be       = is_byte ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                rd_req   = (op != 3'd3) && (op != 3'd4);
                wr_req   = (op == 3'd3) || (op == 3'd4);
                exp_wd   = (op == 3'd4) ? {sdata[7:0], sdata[7:0]} : sdata;
                lat      = l1;
            end else begin
                req_addr = ptr & 16'hFFFE;
                be       = 2'b11;
                rd_req   = (op == 3'd5);
                wr_req   = (op == 3'd6);
                exp_wd   = sdata;
                lat      = l2;
            end
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                mem_resp = 1'b0;
                if (mem_write === 1'b1) write_cycles++;
                checks++;
                if (mem_read !== rd_req || mem_write !== wr_req || mem_address !== req_addr ||
                    mem_byte_enable !== be || (wr_req && mem_wdata !== exp_wd) || wb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL req op=%0d acc=%0d cyc=%0d: got rd=%b wr=%b a=%h be=%b wd=%h wbv=%b want rd=%b wr=%b a=%h be=%b wd=%h wbv=0",
                             op, acc, c, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, wb_valid,
                             rd_req, wr_req, req_addr, be, exp_wd);
                end
                if (c == lat) begin
                    if (rd_req) begin
                        rd = mread(req_addr);
                        mem_rdata = rd;
                    end else begin
                        mwrite(req_addr, be, exp_wd);
                        mem_rdata = 16'($urandom);
                    end
                    if (acc == 0) ptr = rd;
                    mem_resp = 1'b1;
                end
                #1;
                exp_stall = !((c == lat) && (acc == 1 || !ind));
                checks++;
                if (stall_out !== exp_stall) begin
                    errors++;
                    $display("FAIL acc_stall op=%0d acc=%0d cyc=%0d: got %b want %b", op, acc, c, stall_out, exp_stall);
                end
            end
        end
        @(negedge clk);
        mem_resp = 1'b0; valid_in = 1'b0; mem_rdata = 16'($urandom);
        if (is_load) begin
            if (op == 3'd2) begin
                logic [7:0] b;
                b = addr[0] ? rd[15:8] : rd[7:0];
                exp_data = {{8{b[7]}}, b};
            end else begin
                exp_data = rd;
            end
            exp_dr = dr;
            exp_ld = ld;
        end else begin
            exp_ld = 1'b0;
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_dr !== exp_dr ||
            wb_ld_regfile !== exp_ld || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL retire op=%0d: got v=%b d=%h dr=%0d ld=%b rd=%b wr=%b want v=1 d=%h dr=%0d ld=%b rd=0 wr=0",
                     op, wb_valid, wb_data, wb_dr, wb_ld_regfile, mem_read, mem_write, exp_data, exp_dr, exp_ld);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; mem_op_in = '0; addr_in = '0; sdata_in = '0;
        alu_in = '0; dr_in = '0; ld_regfile_in = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_data = '0; exp_dr = '0; exp_ld = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || mem_byte_enable !== 2'b00 ||
            mem_address !== 16'h0 || mem_wdata !== 16'h0 || wb_valid !== 1'b0 || wb_data !== 16'h0 ||
            wb_dr !== 3'd0 || wb_ld_regfile !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got st=%b rd=%b wr=%b be=%b a=%h wd=%h v=%b d=%h dr=%0d ld=%b want all zero",
                     stall_out, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
                     wb_valid, wb_data, wb_dr, wb_ld_regfile);
        end
    endtask

    task automatic test_none();
        @(negedge clk);
        run_none(16'h1234, 3'd3, 1'b1);
        checks++;
        if (wb_data !== 16'h1234 || wb_dr !== 3'd3) begin
            errors++;
            $display("FAIL none_const: got d=%h dr=%0d want 1234 3", wb_data, wb_dr);
        end
    endtask

    task automatic test_ldw();
        mem_model[int'(16'h0041 >> 1)] = 16'hBEEF;
        run_op(3'd1, 16'h0041, 16'h0, 3'd5, 1'b1, 3, 1);
        checks++;
        if (wb_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL ldw_data: got %h want beef", wb_data);
        end
    endtask

    task automatic test_byte();
        mem_model[int'(16'h0100 >> 1)] = 16'h80FF;
        run_op(3'd2, 16'h0101, 16'h0, 3'd1, 1'b1, 1, 1);
        checks++;
        if (wb_data !== 16'hFF80) begin
            errors++;
            $display("FAIL ldb_sext: got %h want ff80", wb_data);
        end
        run_op(3'd4, 16'h0100, 16'h00AB, 3'd2, 1'b1, 2, 1);
        checks++;
        if (wb_ld_regfile !== 1'b0 || wb_data !== 16'hFF80) begin
            errors++;
            $display("FAIL stb_wb: got ld=%b d=%h want ld=0 d=ff80", wb_ld_regfile, wb_data);
        end
        run_op(3'd2, 16'h0100, 16'h0, 3'd4, 1'b1, 1, 1);
        checks++;
        if (wb_data !== 16'hFFAB) begin
            errors++;
            $display("FAIL stb_readback: got %h want ffab", wb_data);
        end
    endtask

    task automatic test_indirect();
        mem_model[int'(16'h0200 >> 1)] = 16'h0301;
        mem_model[int'(16'h0300 >> 1)] = 16'h5555;
        run_op(3'd5, 16'h0200, 16'h0, 3'd6, 1'b1, 1, 2);
        checks++;
        if (wb_data !== 16'h5555) begin
            errors++;
            $display("FAIL ldi_data: got %h want 5555", wb_data);
        end
        mem_model[int'(16'h0400 >> 1)] = 16'h0A11;
        run_op(3'd6, 16'h0400, 16'h1357, 3'd7, 1'b1, 2, 1);
        run_op(3'd1, 16'h0A10, 16'h0, 3'd0, 1'b1, 1, 1);
        checks++;
        if (wb_data !== 16'h1357) begin
            errors++;
            $display("FAIL sti_readback: got %h want 1357", wb_data);
        end
    endtask

    task automatic test_back_to_back();
        write_cycles = 0;
        run_op(3'd3, 16'h0600, 16'hCAFE, 3'd2, 1'b1, 1, 1);
        run_none(16'h7777, 3'd4, 1'b1);
        checks++;
        if (write_cycles !== 1) begin
            errors++;
            $display("FAIL b2b_writes: got %0d want 1", write_cycles);
        end
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1; mem_op_in = 3'd1; addr_in = 16'h0123; dr_in = 3'd1; ld_regfile_in = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: got rd=%b want 1", mem_read);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b0;
        exp_data = '0; exp_dr = '0; exp_ld = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || wb_valid !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: got rd=%b v=%b st=%b want 0 0 0", mem_read, wb_valid, stall_out);
        end
        mem_resp = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_resp = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || mem_read !== 1'b0 || wb_data !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_resp: got v=%b rd=%b d=%h want 0 0 0000", wb_valid, mem_read, wb_data);
        end
        run_none(16'h4242, 3'd6, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                valid_in = 1'($urandom);
                mem_op_in = valid_in ? 3'd7 : 3'($urandom);
                addr_in = 16'($urandom); alu_in = 16'($urandom);
                mem_resp = 1'($urandom); mem_rdata = 16'($urandom);
                #1;
                checks++;
                if (stall_out !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble_stall: got %b want 0", stall_out);
                end
                @(negedge clk);
                mem_resp = 1'b0; valid_in = 1'b0;
                checks++;
                if (wb_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || wb_data !== exp_data) begin
                    errors++;
                    $display("FAIL bubble_wb: got v=%b rd=%b wr=%b d=%h want 0 0 0 %h",
                             wb_valid, mem_read, mem_write, wb_data, exp_data);
                end
            end else begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 6));
                if (op == 3'd0)
                    run_none(16'($urandom), 3'($urandom), 1'($urandom));
                else
                    run_op(op, 16'($urandom_range(0, 255)), 16'($urandom), 3'($urandom), 1'($urandom),
                           int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_ldw();
        test_byte();
        test_indirect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
